// File: rtl/JtagGlobalPkg.sv
// Shared JTAG definitions: TAP state encodings, instruction opcodes, DR
// selection and the legal parameter widths of the target TAP.
package JtagGlobalPkg;

  // Standard 1149.1 state encodings, so tapState reads like a logic analyser trace.
  typedef enum logic [3:0] {
    jtagExit2DrState   = 4'h0,
    jtagExit1DrState   = 4'h1,
    jtagShiftDrState   = 4'h2,
    jtagPauseDrState   = 4'h3,
    jtagIrScanState    = 4'h4,
    jtagUpdateDrState  = 4'h5,
    jtagCaptureDrState = 4'h6,
    jtagDrScanState    = 4'h7,
    jtagExit2IrState   = 4'h8,
    jtagExit1IrState   = 4'h9,
    jtagShiftIrState   = 4'hA,
    jtagPauseIrState   = 4'hB,
    jtagIdleState      = 4'hC,
    jtagUpdateIrState  = 4'hD,
    jtagCaptureIrState = 4'hE,
    jtagResetState     = 4'hF
  } JtagTapStates;

  typedef enum logic [4:0] {
    jtagBypassOpcode       = 5'b00000,
    jtagUserOpcode         = 5'b00001,
    jtagIdcodeOpcode       = 5'b00010,
    jtagBoundaryScanOpcode = 5'b00110
  } JtagInstructionOpcodeEnum;

  typedef enum logic [1:0] {
    drSelBypass,
    drSelUser,
    drSelBsr,
    drSelIdcode
  } JtagDrSelect;

  typedef enum int {
    tvw8  = 8,
    tvw16 = 16,
    tvw24 = 24,
    tvw32 = 32
  } JtagTestVectorWidthEnum;

  typedef enum int {
    iw3 = 3,
    iw4 = 4,
    iw5 = 5
  } JtagInstructionWidthEnum;

  localparam int JTAG_IDCODE_WIDTH = 32;

  function automatic bit legalTestVectorWidth(input int w);
    return (w == tvw8) || (w == tvw16) || (w == tvw24) || (w == tvw32);
  endfunction

  function automatic bit legalInstructionWidth(input int w);
    return (w == iw3) || (w == iw4) || (w == iw5);
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state IEEE 1149.1 TAP controller; exposes the state plus capture/shift/
// update strobes for the IR and DR paths (at most one strobe high at a time).
module jtag_tap_fsm
  import JtagGlobalPkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         jtagTms,
  output JtagTapStates state,
  output logic         captureIr,
  output logic         shiftIr,
  output logic         updateIr,
  output logic         captureDr,
  output logic         shiftDr,
  output logic         updateDr
);

  JtagTapStates nextState;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= jtagResetState;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      jtagResetState:     nextState = jtagTms ? jtagResetState    : jtagIdleState;
      jtagIdleState:      nextState = jtagTms ? jtagDrScanState   : jtagIdleState;
      jtagDrScanState:    nextState = jtagTms ? jtagIrScanState   : jtagCaptureDrState;
      jtagCaptureDrState: nextState = jtagTms ? jtagExit1DrState  : jtagShiftDrState;
      jtagShiftDrState:   nextState = jtagTms ? jtagExit1DrState  : jtagShiftDrState;
      jtagExit1DrState:   nextState = jtagTms ? jtagUpdateDrState : jtagPauseDrState;
      jtagPauseDrState:   nextState = jtagTms ? jtagExit2DrState  : jtagPauseDrState;
      jtagExit2DrState:   nextState = jtagTms ? jtagUpdateDrState : jtagShiftDrState;
      jtagUpdateDrState:  nextState = jtagTms ? jtagDrScanState   : jtagIdleState;
      jtagIrScanState:    nextState = jtagTms ? jtagResetState    : jtagCaptureIrState;
      jtagCaptureIrState: nextState = jtagTms ? jtagExit1IrState  : jtagShiftIrState;
      jtagShiftIrState:   nextState = jtagTms ? jtagExit1IrState  : jtagShiftIrState;
      jtagExit1IrState:   nextState = jtagTms ? jtagUpdateIrState : jtagPauseIrState;
      jtagPauseIrState:   nextState = jtagTms ? jtagExit2IrState  : jtagPauseIrState;
      jtagExit2IrState:   nextState = jtagTms ? jtagUpdateIrState : jtagShiftIrState;
      jtagUpdateIrState:  nextState = jtagTms ? jtagDrScanState   : jtagIdleState;
      default:            nextState = jtagResetState;
    endcase
  end

  always_comb begin
    captureIr = (state == jtagCaptureIrState);
    shiftIr   = (state == jtagShiftIrState);
    updateIr  = (state == jtagUpdateIrState);
    captureDr = (state == jtagCaptureDrState);
    shiftDr   = (state == jtagShiftDrState);
    updateDr  = (state == jtagUpdateDrState);
  end

endmodule

// File: rtl/jtag_target_tap.sv
// Target-side JTAG TAP: IR, bypass/user/boundary-scan DRs and TDO driver.
// Define JTAG_IDCODE_EN to add the 32-bit IDCODE DR and make it the reset instruction.
module jtag_target_tap
  import JtagGlobalPkg::*;
#(
  parameter int          TEST_VECTOR_WIDTH = 32,
  parameter int          INSTRUCTION_WIDTH = 5,
  parameter logic [31:0] IDCODE_VALUE      = 32'h1234_5679
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         jtagTms,
  input  logic                         jtagTdi,
  output logic                         jtagTdo,
  output logic                         jtagTdoEn,
  output logic [3:0]                   tapState,
  output logic [INSTRUCTION_WIDTH-1:0] instruction,
  output logic [TEST_VECTOR_WIDTH-1:0] userRegOut,
  input  logic [TEST_VECTOR_WIDTH-1:0] bsrParallelIn,
  output logic [TEST_VECTOR_WIDTH-1:0] bsrParallelOut
);

  localparam int TVW = TEST_VECTOR_WIDTH;
  localparam int IW  = INSTRUCTION_WIDTH;
  localparam logic [IW-1:0] IR_CAPTURE = IW'(2'b01);
`ifdef JTAG_IDCODE_EN
  localparam logic [IW-1:0] RESET_INSTR = IW'(jtagIdcodeOpcode);
`else
  localparam logic [IW-1:0] RESET_INSTR = IW'(jtagBypassOpcode);
`endif

  if (!legalTestVectorWidth(TEST_VECTOR_WIDTH)) begin : gBadTvw
    $error("jtag_target_tap: TEST_VECTOR_WIDTH must be 8, 16, 24 or 32");
  end
  if (!legalInstructionWidth(INSTRUCTION_WIDTH)) begin : gBadIw
    $error("jtag_target_tap: INSTRUCTION_WIDTH must be 3, 4 or 5");
  end
  if (IDCODE_VALUE[0] != 1'b1) begin : gBadIdcode
    $error("jtag_target_tap: IDCODE_VALUE bit 0 must be 1");
  end

  JtagTapStates state;
  logic captureIr, shiftIr, updateIr, captureDr, shiftDr, updateDr;

  jtag_tap_fsm uFsm (
    .clk      (clk),
    .reset    (reset),
    .jtagTms  (jtagTms),
    .state    (state),
    .captureIr(captureIr),
    .shiftIr  (shiftIr),
    .updateIr (updateIr),
    .captureDr(captureDr),
    .shiftDr  (shiftDr),
    .updateDr (updateDr)
  );

  assign tapState = state;

  logic [IW-1:0]  irShift;
  logic [4:0]     opcode;
  JtagDrSelect    drSel;
  logic           bypassReg;
  logic [TVW-1:0] userShift;
  logic [TVW-1:0] bsrShift;
  logic           selLsb;

  // Narrow IRs are decoded as if zero-extended to the full 5-bit opcode space.
  assign opcode = 5'(instruction);

  always_comb begin
    drSel = drSelBypass;
    case (opcode)
      jtagUserOpcode:         drSel = drSelUser;
      jtagBoundaryScanOpcode: drSel = drSelBsr;
`ifdef JTAG_IDCODE_EN
      jtagIdcodeOpcode:       drSel = drSelIdcode;
`endif
      default:                drSel = drSelBypass;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irShift     <= '0;
      instruction <= RESET_INSTR;
    end else begin
      if (captureIr)    irShift <= IR_CAPTURE;
      else if (shiftIr) irShift <= {jtagTdi, irShift[IW-1:1]};
      if (state == jtagResetState) instruction <= RESET_INSTR;
      else if (updateIr)           instruction <= irShift;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bypassReg      <= 1'b0;
      userShift      <= '0;
      bsrShift       <= '0;
      userRegOut     <= '0;
      bsrParallelOut <= '0;
    end else begin
      case (drSel)
        drSelBypass: begin
          if (captureDr)    bypassReg <= 1'b0;
          else if (shiftDr) bypassReg <= jtagTdi;
        end
        drSelUser: begin
          if (captureDr)    userShift <= userRegOut;
          else if (shiftDr) userShift <= {jtagTdi, userShift[TVW-1:1]};
          if (updateDr)     userRegOut <= userShift;
        end
        drSelBsr: begin
          if (captureDr)    bsrShift <= bsrParallelIn;
          else if (shiftDr) bsrShift <= {jtagTdi, bsrShift[TVW-1:1]};
          if (updateDr)     bsrParallelOut <= bsrShift;
        end
        default: ;
      endcase
    end
  end

`ifdef JTAG_IDCODE_EN
  logic [JTAG_IDCODE_WIDTH-1:0] idShift;

  // Read-only register: no update path.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) idShift <= '0;
    else if (drSel == drSelIdcode) begin
      if (captureDr)    idShift <= IDCODE_VALUE;
      else if (shiftDr) idShift <= {jtagTdi, idShift[JTAG_IDCODE_WIDTH-1:1]};
    end
  end
`endif

  always_comb begin
    selLsb = 1'b0;
    if (shiftIr) selLsb = irShift[0];
    else begin
      case (drSel)
        drSelBypass: selLsb = bypassReg;
        drSelUser:   selLsb = userShift[0];
        drSelBsr:    selLsb = bsrShift[0];
`ifdef JTAG_IDCODE_EN
        drSelIdcode: selLsb = idShift[0];
`endif
        default:     selLsb = 1'b0;
      endcase
    end
  end

  // TDO changes on the falling edge so the initiator samples a settled bit on the next rise.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      jtagTdo   <= 1'b0;
      jtagTdoEn <= 1'b0;
    end else if (shiftIr || shiftDr) begin
      jtagTdo   <= selLsb;
      jtagTdoEn <= 1'b1;
    end else begin
      jtagTdo   <= 1'b0;
      jtagTdoEn <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jtag_target_tap.sv
// Self-checking bench for jtag_target_tap: drives TMS/TDI bit by bit and
// scores TDO scans against an expected queue.
module tb_jtag_target_tap;
  import JtagGlobalPkg::*;

  localparam int TVW = 32;
  localparam int IW  = 5;
`ifdef JTAG_IDCODE_EN
  localparam logic [IW-1:0] RESET_INSTR = 5'b00010;
`else
  localparam logic [IW-1:0] RESET_INSTR = 5'b00000;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           jtagTms = 1'b1;
  logic           jtagTdi = 1'b0;
  logic           jtagTdo;
  logic           jtagTdoEn;
  logic [3:0]     tapState;
  logic [IW-1:0]  instruction;
  logic [TVW-1:0] userRegOut;
  logic [TVW-1:0] bsrParallelIn = '0;
  logic [TVW-1:0] bsrParallelOut;

  int checks = 0;
  int failures = 0;
  logic [31:0] expQ[$];
  logic [31:0] modelUser = '0;
  logic [31:0] modelBsr = '0;

  jtag_target_tap #(
    .TEST_VECTOR_WIDTH(TVW),
    .INSTRUCTION_WIDTH(IW),
    .IDCODE_VALUE     (32'h1234_5679)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .jtagTms       (jtagTms),
    .jtagTdi       (jtagTdi),
    .jtagTdo       (jtagTdo),
    .jtagTdoEn     (jtagTdoEn),
    .tapState      (tapState),
    .instruction   (instruction),
    .userRegOut    (userRegOut),
    .bsrParallelIn (bsrParallelIn),
    .bsrParallelOut(bsrParallelOut)
  );

  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic tick(input logic tms, input logic tdi);
    jtagTms = tms;
    jtagTdi = tdi;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // Starts in Shift-xR with bit 0 already on TDO, ends in Exit1-xR.
  task automatic shiftBits(input int n, input logic [31:0] din,
                           output logic [31:0] dout, output logic enOk);
    dout = '0;
    enOk = 1'b1;
    for (int i = 0; i < n; i++) begin
      dout[i] = jtagTdo;
      if (jtagTdoEn !== 1'b1) enOk = 1'b0;
      tick(i == n - 1, din[i]);
    end
  endtask

  task automatic toShiftDr();
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  task automatic exitUpdate();
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  task automatic loadIr(input logic [IW-1:0] op, output logic [31:0] captured);
    logic en;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    shiftBits(IW, 32'(op), captured, en);
    exitUpdate();
  endtask

  task automatic applyReset();
    reset = 1'b0;
    jtagTms = 1'b1;
    jtagTdi = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (tapState !== 4'(jtagResetState) || instruction !== RESET_INSTR) begin
      failures++;
      $display("FAIL reset_state: tapState=%h instruction=%b required %h/%b",
               tapState, instruction, 4'(jtagResetState), RESET_INSTR);
    end
    checks++;
    if (jtagTdo !== 1'b0 || jtagTdoEn !== 1'b0 || userRegOut !== '0 || bsrParallelOut !== '0) begin
      failures++;
      $display("FAIL reset_outputs: tdo=%b en=%b user=%h bsr=%h required all 0",
               jtagTdo, jtagTdoEn, userRegOut, bsrParallelOut);
    end
    reset = 1'b1;
    tick(1'b1, 1'b0);
    checks++;
    if (tapState !== 4'(jtagResetState)) begin
      failures++;
      $display("FAIL reset_hold: tapState=%h required %h", tapState, 4'(jtagResetState));
    end
    tick(1'b0, 1'b0);
    checks++;
    if (tapState !== 4'(jtagIdleState)) begin
      failures++;
      $display("FAIL reset_to_idle: tapState=%h required %h", tapState, 4'(jtagIdleState));
    end
  endtask

  task automatic test_ir_load();
    logic [31:0] cap;
    logic en;
    logic [31:0] exp;
    expQ.push_back(32'h0000_0001);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    checks++;
    if (tapState !== 4'(jtagCaptureIrState)) begin
      failures++;
      $display("FAIL ir_capture_state: tapState=%h required %h", tapState, 4'(jtagCaptureIrState));
    end
    tick(1'b0, 1'b0);
    shiftBits(IW, 32'h0000_0006, cap, en);
    checks++;
    if (tapState !== 4'(jtagExit1IrState) || instruction !== RESET_INSTR) begin
      failures++;
      $display("FAIL ir_exit1_hold: tapState=%h instruction=%b required %h/%b",
               tapState, instruction, 4'(jtagExit1IrState), RESET_INSTR);
    end
    tick(1'b1, 1'b0);
    checks++;
    if (tapState !== 4'(jtagUpdateIrState) || instruction !== RESET_INSTR) begin
      failures++;
      $display("FAIL ir_update_entry: tapState=%h instruction=%b required %h/%b",
               tapState, instruction, 4'(jtagUpdateIrState), RESET_INSTR);
    end
    tick(1'b0, 1'b0);
    checks++;
    if (instruction !== 5'b00110) begin
      failures++;
      $display("FAIL ir_update: instruction=%b required 00110", instruction);
    end
    exp = expQ.pop_front();
    checks++;
    if (cap !== exp || en !== 1'b1) begin
      failures++;
      $display("FAIL ir_shift_out: got=%h en=%b required %h en=1", cap, en, exp);
    end
  endtask

  task automatic runBypass(input logic [IW-1:0] op, input logic [7:0] din);
    logic [31:0] cap;
    logic [31:0] dout;
    logic [31:0] exp;
    logic en;
    loadIr(op, cap);
    expQ.push_back({24'h0, din[6:0], 1'b0});
    toShiftDr();
    shiftBits(8, {24'h0, din}, dout, en);
    exitUpdate();
    exp = expQ.pop_front();
    checks++;
    if (dout !== exp || en !== 1'b1) begin
      failures++;
      $display("FAIL bypass_op%b: tdo=%h en=%b required %h en=1", op, dout, en, exp);
    end
    checks++;
    if (userRegOut !== modelUser || bsrParallelOut !== modelBsr) begin
      failures++;
      $display("FAIL bypass_no_update_op%b: user=%h bsr=%h required %h/%h",
               op, userRegOut, bsrParallelOut, modelUser, modelBsr);
    end
  endtask

  task automatic test_bypass();
    runBypass(5'b00000, 8'b1011_0010);
    runBypass(5'b00111, 8'($urandom_range(0, 255)));
    runBypass(5'b11111, 8'($urandom_range(0, 255)));
`ifndef JTAG_IDCODE_EN
    runBypass(5'b00010, 8'($urandom_range(0, 255)));
`endif
  endtask

  task automatic test_reset_mid_shift();
    logic [31:0] cap;
    loadIr(5'b00110, cap);
    bsrParallelIn = $urandom;
    toShiftDr();
    for (int i = 0; i < 10; i++) tick(1'b0, 1'($urandom_range(0, 1)));
    reset = 1'b0;
    #2;
    checks++;
    if (tapState !== 4'(jtagResetState) || instruction !== RESET_INSTR ||
        jtagTdoEn !== 1'b0 || bsrParallelOut !== '0) begin
      failures++;
      $display("FAIL reset_mid_shift: state=%h instr=%b en=%b bsr=%h required %h/%b/0/0",
               tapState, instruction, jtagTdoEn, bsrParallelOut, 4'(jtagResetState), RESET_INSTR);
    end
    @(negedge clk);
    #1;
    reset = 1'b1;
    modelUser = '0;
    modelBsr = '0;
    tick(1'b0, 1'b0);
  endtask

  task automatic test_bsr();
    logic [31:0] cap;
    logic [31:0] dout;
    logic [31:0] exp;
    logic en;
    loadIr(5'b00110, cap);
    bsrParallelIn = 32'hA5A5_0F0F;
    expQ.push_back(32'hA5A5_0F0F);
    toShiftDr();
    shiftBits(32, 32'hDEAD_BEEF, dout, en);
    bsrParallelIn = 32'h0;
    tick(1'b1, 1'b0);
    checks++;
    if (bsrParallelOut !== modelBsr) begin
      failures++;
      $display("FAIL bsr_before_update: bsr=%h required %h", bsrParallelOut, modelBsr);
    end
    tick(1'b0, 1'b0);
    modelBsr = 32'hDEAD_BEEF;
    checks++;
    if (bsrParallelOut !== modelBsr) begin
      failures++;
      $display("FAIL bsr_update: bsr=%h required %h", bsrParallelOut, modelBsr);
    end
    exp = expQ.pop_front();
    checks++;
    if (dout !== exp || en !== 1'b1) begin
      failures++;
      $display("FAIL bsr_capture: tdo=%h en=%b required %h en=1", dout, en, exp);
    end
  endtask

  task automatic userWrite(input logic [31:0] w, input logic withPause, input string tag);
    logic [31:0] cap;
    logic [31:0] lo;
    logic [31:0] hi;
    logic [31:0] exp;
    logic en1;
    logic en2;
    loadIr(5'b00001, cap);
    expQ.push_back(modelUser);
    toShiftDr();
    if (withPause) begin
      shiftBits(16, {16'h0, w[15:0]}, lo, en1);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      checks++;
      if (tapState !== 4'(jtagPauseDrState) || jtagTdoEn !== 1'b0) begin
        failures++;
        $display("FAIL %s_pause: state=%h en=%b required %h en=0",
                 tag, tapState, jtagTdoEn, 4'(jtagPauseDrState));
      end
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      checks++;
      if (userRegOut !== modelUser || tapState !== 4'(jtagShiftDrState)) begin
        failures++;
        $display("FAIL %s_resume: user=%h state=%h required %h/%h",
                 tag, userRegOut, tapState, modelUser, 4'(jtagShiftDrState));
      end
      shiftBits(16, {16'h0, w[31:16]}, hi, en2);
      lo = {hi[15:0], lo[15:0]};
    end else begin
      shiftBits(32, w, lo, en1);
      en2 = 1'b1;
    end
    exitUpdate();
    modelUser = w;
    exp = expQ.pop_front();
    checks++;
    if (lo !== exp || en1 !== 1'b1 || en2 !== 1'b1) begin
      failures++;
      $display("FAIL %s_readback: tdo=%h en=%b%b required %h en=11", tag, lo, en1, en2, exp);
    end
    checks++;
    if (userRegOut !== modelUser) begin
      failures++;
      $display("FAIL %s_update: user=%h required %h", tag, userRegOut, modelUser);
    end
  endtask

  task automatic test_user_pause();
    userWrite(32'hC0DE_1234, 1'b0, "user_plain");
    userWrite(32'h5A5A_3C3C, 1'b1, "user_pause");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) userWrite($urandom, 1'($urandom_range(0, 1)), "user_b2b");
  endtask

  task automatic test_tms_reset();
    logic [31:0] cap;
    toShiftDr();
    repeat (5) tick(1'b1, 1'($urandom_range(0, 1)));
    checks++;
    if (tapState !== 4'(jtagResetState)) begin
      failures++;
      $display("FAIL tms_reset_from_shiftdr: state=%h required %h", tapState, 4'(jtagResetState));
    end
    tick(1'b0, 1'b0);
    checks++;
    if (tapState !== 4'(jtagIdleState) || instruction !== RESET_INSTR) begin
      failures++;
      $display("FAIL tms_reset_instr: state=%h instr=%b required %h/%b",
               tapState, instruction, 4'(jtagIdleState), RESET_INSTR);
    end
    loadIr(5'b00001, cap);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    repeat (5) tick(1'b1, 1'b0);
    checks++;
    if (tapState !== 4'(jtagResetState)) begin
      failures++;
      $display("FAIL tms_reset_from_pauseir: state=%h required %h", tapState, 4'(jtagResetState));
    end
    tick(1'b0, 1'b0);
  endtask

  task automatic test_idcode();
    logic [31:0] din;
    logic [31:0] dout;
    logic [31:0] exp;
    logic en;
    applyReset();
    tick(1'b0, 1'b0);
    din = $urandom;
`ifdef JTAG_IDCODE_EN
    expQ.push_back(32'h1234_5679);
`else
    expQ.push_back({din[30:0], 1'b0});
`endif
    toShiftDr();
    shiftBits(32, din, dout, en);
    exitUpdate();
    exp = expQ.pop_front();
    checks++;
    if (dout !== exp || en !== 1'b1) begin
      failures++;
      $display("FAIL reset_instr_scan: tdo=%h en=%b required %h en=1", dout, en, exp);
    end
  endtask

  initial begin
    applyReset();
    test_reset();
    test_ir_load();
    test_bypass();
    test_reset_mid_shift();
    test_bsr();
    test_user_pause();
    test_back_to_back();
    test_tms_reset();
    test_idcode();
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: entries=%0d required 0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
